// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct and select encodings for the multi-cycle controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_RT       = 2'd0;
    localparam logic [1:0] SRCB_FOUR     = 2'd1;
    localparam logic [1:0] SRCB_IMM      = 2'd2;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // States whose exit edge completes an instruction.
    function automatic logic isRetireState(input state_t s);
        return (s == MEMWB) || (s == MEMWR) || (s == ALUWB) ||
               (s == ADDIWB) || (s == BRANCH) || (s == JUMP);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU operation decode with a supported-funct flag
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] aluOperation,
    output logic       isValid
);

    always_comb begin
        aluOperation = ALU_ADD;
        isValid      = 1'b1;
        case (funct)
            FN_ADD:  aluOperation = ALU_ADD;
            FN_SUB:  aluOperation = ALU_SUB;
            FN_AND:  aluOperation = ALU_AND;
            FN_OR:   aluOperation = ALU_OR;
            FN_SLT:  aluOperation = ALU_SLT;
            default: isValid      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM sequencing the shared multi-cycle MIPS datapath
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             isZero,
    output logic             enablePCWrite,
    output logic             selectIorD,
    output logic             enableMemRead,
    output logic             enableMemWrite,
    output logic             enableIRWrite,
    output logic             selectRegDst,
    output logic             selectMemToReg,
    output logic             enableRegWrite,
    output logic             selectALUSrcA,
    output logic [1:0]       selectALUSrcB,
    output logic [3:0]       ALUOperation,
    output logic [1:0]       selectPCSrc,
    output logic             illegalOp,
    output logic [CNT_W-1:0] retiredCount
);

    state_t     state;
    state_t     nextState;
    logic [3:0] functAluOp;
    logic       functValid;

    alu_decoder uAluDecoder (
        .funct        (funct),
        .aluOperation (functAluOp),
        .isValid      (functValid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retiredCount <= '0;
        end else if (isRetireState(state)) begin
            retiredCount <= retiredCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:  nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_ADDI:      nextState = ADDIEX;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    default:      nextState = FETCH;
                endcase
            end
            MEMADR: nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  nextState = MEMWB;
            EXEC:   nextState = functValid ? ALUWB : FETCH;
            ADDIEX: nextState = ADDIWB;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        enablePCWrite  = 1'b0;
        selectIorD     = 1'b0;
        enableMemRead  = 1'b0;
        enableMemWrite = 1'b0;
        enableIRWrite  = 1'b0;
        selectRegDst   = 1'b0;
        selectMemToReg = 1'b0;
        enableRegWrite = 1'b0;
        selectALUSrcA  = 1'b0;
        selectALUSrcB  = SRCB_RT;
        ALUOperation   = ALU_AND;
        selectPCSrc    = PCSRC_ALU;
        illegalOp      = 1'b0;
        case (state)
            FETCH: begin
                enableMemRead = 1'b1;
                enableIRWrite = 1'b1;
                selectALUSrcB = SRCB_FOUR;
                ALUOperation  = ALU_ADD;
                enablePCWrite = 1'b1;
            end
            DECODE: begin
                // Branch target is precomputed here so BRANCH can load it from ALUOut.
                selectALUSrcB = SRCB_IMM_SHL2;
                ALUOperation  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J: illegalOp = 1'b0;
                    default:                                      illegalOp = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                selectALUSrcA = 1'b1;
                selectALUSrcB = SRCB_IMM;
                ALUOperation  = ALU_ADD;
            end
            MEMRD: begin
                enableMemRead = 1'b1;
                selectIorD    = 1'b1;
            end
            MEMWB: begin
                enableRegWrite = 1'b1;
                selectMemToReg = 1'b1;
            end
            MEMWR: begin
                enableMemWrite = 1'b1;
                selectIorD     = 1'b1;
            end
            EXEC: begin
                selectALUSrcA = 1'b1;
                ALUOperation  = functValid ? functAluOp : ALU_ADD;
                illegalOp     = !functValid;
            end
            ALUWB: begin
                enableRegWrite = 1'b1;
                selectRegDst   = 1'b1;
            end
            ADDIWB: begin
                enableRegWrite = 1'b1;
            end
            BRANCH: begin
                selectALUSrcA = 1'b1;
                ALUOperation  = ALU_SUB;
                selectPCSrc   = PCSRC_ALUOUT;
                enablePCWrite = isZero;
            end
            JUMP: begin
                selectPCSrc   = PCSRC_JUMP;
                enablePCWrite = 1'b1;
            end
            default: begin
                enablePCWrite = 1'b0;
            end
        endcase
        // Strobes are suppressed for the whole reset window, whatever the state register holds.
        if (reset) begin
            enablePCWrite  = 1'b0;
            enableMemRead  = 1'b0;
            enableMemWrite = 1'b0;
            enableIRWrite  = 1'b0;
            enableRegWrite = 1'b0;
            illegalOp      = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control state machine for the multi-cycle MIPS core. It issues the per-cycle control strobes that sequence the shared datapath: register file, ALU, unified memory, instruction register and PC. It consumes the opcode, funct and ALU zero flag that the datapath returns. It retires one instruction every 3–5 cycles and counts retired instructions for the bench.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0] from instruction register
- isZero  in  1  ALU zero flag, combinational from datapath
- enablePCWrite  out  1  PC load strobe (unconditional OR branch-taken)
- selectIorD  out  1  memory address: 0=PC, 1=ALUOut
- enableMemRead  out  1  memory read strobe
- enableMemWrite  out  1  memory write strobe
- enableIRWrite  out  1  instruction register load
- selectRegDst  out  1  write reg: 0=rt, 1=rd
- selectMemToReg  out  1  write data: 0=ALUOut, 1=MDR
- enableRegWrite  out  1  register file write
- selectALUSrcA  out  1  0=PC, 1=rs
- selectALUSrcB  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ALUOperation  out  4  ALU op code
- selectPCSrc  out  2  0=ALU result, 1=ALUOut, 2=jump target
- illegalOp  out  1  one-cycle pulse on unsupported opcode/funct
- retiredCount  out  CNT_W  instructions completed, wraps

## Operation
- Decoded opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- R-type functs: ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
- ALUOperation encodings: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111.
- Unlisted strobes are 0 in every state. selectALUSrcB, selectPCSrc and ALUOperation default to 0.
- FETCH: MemRead=1, IorD=0, IRWrite=1, SrcA=0, SrcB=1, ALU=ADD, PCSrc=0, PCWrite=1. Next state DECODE.
- DECODE: SrcA=0, SrcB=3, ALU=ADD (branch target into ALUOut).
  - LW or SW → MEMADR; R → EXEC; ADDI → ADDIEX; BEQ → BRANCH; J → JUMP.
  - Any other opcode → FETCH, with illegalOp=1 in DECODE.
- MEMADR: SrcA=1, SrcB=2, ALU=ADD. LW → MEMRD; SW → MEMWR.
- MEMRD: MemRead=1, IorD=1. Next state MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1. Next state FETCH; retires.
- MEMWR: MemWrite=1, IorD=1. Next state FETCH; retires.
- EXEC: SrcA=1, SrcB=0, ALU from funct.
  - Supported funct → ALUWB.
  - Unsupported funct → FETCH, with illegalOp=1 and ALU=ADD; no register write; not retired.
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0. Next state FETCH; retires.
- ADDIEX: SrcA=1, SrcB=2, ALU=ADD. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. Next state FETCH; retires.
- BRANCH: SrcA=1, SrcB=0, ALU=SUB, PCSrc=1, enablePCWrite=isZero. Next state FETCH; retires whether taken or not.
- JUMP: PCSrc=2, PCWrite=1. Next state FETCH; retires.
- retiredCount increments by 1 on the rising edge that leaves a retiring state. It wraps 2^CNT_W−1 → 0.
- isZero is sampled only in BRANCH. It is ignored in every other state.

## Timing
- Outputs are combinational from the registered state only, except enablePCWrite in BRANCH, which also depends on isZero.
- Cycles per instruction: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3. Illegal opcode 2; illegal funct 3.
- Reset:
  - While reset=1, every enable/strobe output is forced to 0: PCWrite, MemRead, MemWrite, IRWrite, RegWrite, illegalOp.
  - At the first edge with reset=1, state becomes FETCH and retiredCount becomes 0.
  - After reset deasserts, FETCH strobes appear in the same cycle.
- Reset mid-instruction aborts it: no retire count, and the next non-reset cycle is FETCH.
- opcode and funct must be stable from DECODE through the end of the instruction. The IR only loads in FETCH.

## Structure
- Shared package mips_ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP (4-bit);
  - opcode and funct constants;
  - ALUOperation constants;
  - SrcB and PCSrc select constants.
- One sub-module, alu_decoder: combinational funct → ALUOperation plus a valid flag. The top block holds the state register, next-state logic, output decode and counter.

## Test plan
- Reset held 3 cycles mid-MEMRD, then released → all strobes 0 during reset; FETCH strobes (MemRead=1, IRWrite=1, PCWrite=1, SrcB=1) in the first cycle after; retiredCount=0.
- LW (opcode 100011) → 5-cycle sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; MEMWB has RegWrite=1, MemToReg=1, RegDst=0; retiredCount +1.
- R-type SUB (funct 100010) → EXEC drives ALUOperation=0110; ALUWB has RegWrite=1, RegDst=1; 4 cycles total.
- BEQ with isZero=1 and then isZero=0 → BRANCH has PCSrc=1 with PCWrite 1 then 0; both retire (+2).
- Opcode 111111 → illegalOp pulse in DECODE, back to FETCH next cycle, retiredCount unchanged; R-type funct 000000 → illegalOp in EXEC, no RegWrite.
- Preload retiredCount to 0xFFFF (CNT_W=16) by running 65535 J instructions, then one more J → count wraps to 0x0000.
